// File: rtl/sa_pkg.sv
`default_nettype none
// ==========================================================================
// sa_pkg -- shared systolic-array defaults and feeder state encoding | rev 1.0
// ==========================================================================
package sa_pkg;

  localparam int BIT_WIDTH_DEF = 16;
  localparam int N_DEF         = 4;
  localparam int K_W_DEF       = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } feeder_state_t;

  // Cycles needed for the last skewed operand to reach PE(N-1,N-1).
  function automatic int flush_len(input int n);
    return 2 * n - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_feeder_if.sv
`default_nettype none
// ==========================================================================
// systolic_feeder_if -- beat handshake and PE edge buses (FEEDER_BUBBLE_CNT_EN) | rev 1.0
// ==========================================================================
interface systolic_feeder_if
  import sa_pkg::*;
#(
  parameter int BIT_WIDTH = BIT_WIDTH_DEF,
  parameter int N         = N_DEF,
  parameter int K_W       = K_W_DEF
);
  logic                   start;
  logic [K_W-1:0]         k_len;
  logic                   in_valid;
  logic                   in_ready;
  logic [N*BIT_WIDTH-1:0] a_vec;
  logic [N*BIT_WIDTH-1:0] b_vec;
  logic [N*BIT_WIDTH-1:0] west_data;
  logic [N*BIT_WIDTH-1:0] north_data;
  logic                   busy;
  logic                   done;

`ifdef FEEDER_BUBBLE_CNT_EN
  logic [15:0]            bubble_cnt;

  modport master (
    output start, k_len, in_valid, a_vec, b_vec,
    input  in_ready, west_data, north_data, busy, done, bubble_cnt
  );
  modport slave (
    input  start, k_len, in_valid, a_vec, b_vec,
    output in_ready, west_data, north_data, busy, done, bubble_cnt
  );
`else
  modport master (
    output start, k_len, in_valid, a_vec, b_vec,
    input  in_ready, west_data, north_data, busy, done
  );
  modport slave (
    input  start, k_len, in_valid, a_vec, b_vec,
    output in_ready, west_data, north_data, busy, done
  );
`endif

endinterface
`default_nettype wire

// File: rtl/systolic_feeder_skew_line.sv
`default_nettype none
// ==========================================================================
// skew_line -- DEPTH-stage shift register, async reset to zero | rev 1.0
// ==========================================================================
module skew_line
  import sa_pkg::*;
#(
  parameter int DEPTH     = 1,
  parameter int BIT_WIDTH = BIT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] d,
  output logic [BIT_WIDTH-1:0] q
);

  logic [BIT_WIDTH-1:0] stage_q [DEPTH];
  logic [BIT_WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = d;
    for (int s = 1; s < DEPTH; s++) begin
      stage_d[s] = stage_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// ==========================================================================
// systolic_feeder -- skewed A/B edge feeder for an NxN PE grid; optional
// bubble counter under FEEDER_BUBBLE_CNT_EN | rev 1.0
// ==========================================================================
module systolic_feeder
  import sa_pkg::*;
#(
  parameter int BIT_WIDTH = BIT_WIDTH_DEF,
  parameter int N         = N_DEF,
  parameter int K_W       = K_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  systolic_feeder_if.slave  bus
);

  localparam int FLUSH_LEN = flush_len(N);
  localparam int FC_W      = $clog2(FLUSH_LEN + 1);

  feeder_state_t    state_q, state_d;
  logic [K_W-1:0]   k_len_q, k_len_d;
  logic [K_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;

  logic [N*BIT_WIDTH-1:0] west_w;
  logic [N*BIT_WIDTH-1:0] north_w;

  assign accept = bus.in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          beat_cnt_d  = '0;
          flush_cnt_d = '0;
          if (bus.k_len != '0) begin
            k_len_d = bus.k_len;
            state_d = ST_STREAM;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_STREAM: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + K_W'(1);
          if (beat_cnt_d == k_len_q) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = '0;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FC_W'(FLUSH_LEN - 1)) begin
          state_d = ST_DONE;
        end else begin
          flush_cnt_d = flush_cnt_q + FC_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered from the next-state decode so they align with state_q.
    in_ready_d = (state_d == ST_STREAM);
    busy_d     = (state_d == ST_STREAM) || (state_d == ST_FLUSH);
    done_d     = (state_d == ST_DONE);
  end

`ifdef FEEDER_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (state_q == ST_IDLE && bus.start) begin
      bubble_cnt_d = '0;
    end else if (state_q == ST_STREAM && !bus.in_valid && bubble_cnt_q != 16'hFFFF) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  assign bus.bubble_cnt = bubble_cnt_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      k_len_q      <= '0;
      beat_cnt_q   <= '0;
      flush_cnt_q  <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef FEEDER_BUBBLE_CNT_EN
      bubble_cnt_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      k_len_q      <= k_len_d;
      beat_cnt_q   <= beat_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef FEEDER_BUBBLE_CNT_EN
      bubble_cnt_q <= bubble_cnt_d;
`endif
    end
  end

  // Non-accepted cycles push zeros so bubbles and flush never disturb accumulators.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [BIT_WIDTH-1:0] a_in;
    logic [BIT_WIDTH-1:0] b_in;

    assign a_in = accept ? bus.a_vec[i*BIT_WIDTH +: BIT_WIDTH] : '0;
    assign b_in = accept ? bus.b_vec[i*BIT_WIDTH +: BIT_WIDTH] : '0;

    skew_line #(.DEPTH(i + 1), .BIT_WIDTH(BIT_WIDTH)) u_west (
      .clk (clk),
      .rst (rst),
      .d   (a_in),
      .q   (west_w[i*BIT_WIDTH +: BIT_WIDTH])
    );

    skew_line #(.DEPTH(i + 1), .BIT_WIDTH(BIT_WIDTH)) u_north (
      .clk (clk),
      .rst (rst),
      .d   (b_in),
      .q   (north_w[i*BIT_WIDTH +: BIT_WIDTH])
    );
  end

  assign bus.west_data  = west_w;
  assign bus.north_data = north_w;
  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ==========================================================================
// tb_systolic_feeder -- directed bench with a PE-grid model (FEEDER_BUBBLE_CNT_EN) | rev 1.0
// ==========================================================================
module tb_systolic_feeder;
  import sa_pkg::*;

  localparam int BW = 16;
  localparam int NN = 4;
  localparam int KW = 8;
  localparam int LW = NN * BW;
  localparam int HMAX = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_feeder_if #(.BIT_WIDTH(BW), .N(NN), .K_W(KW)) bus ();

  systolic_feeder #(.BIT_WIDTH(BW), .N(NN), .K_W(KW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [LW-1:0] west;
    logic [LW-1:0] north;
    logic          busy;
    logic          done;
  } vec_t;

  vec_t tbl [8];

  logic [LW-1:0] wh [HMAX];
  logic [LW-1:0] nh [HMAX];
  int            hist_len;
  int            a_m [NN][NN];
  int            b_m [NN][NN];
  bit            vpat [$];
  int            lane0_leak;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int k);
    for (int i = 0; i < NN; i++) begin
      bus.a_vec[i*BW +: BW] = a_m[i][k][BW-1:0];
      bus.b_vec[i*BW +: BW] = b_m[k][i][BW-1:0];
    end
  endtask

  // PE(i,j) sees west lane i delayed j hops and north lane j delayed i hops.
  function automatic longint pe_acc(input int i, input int j);
    longint s = 0;
    logic signed [BW-1:0] av;
    logic signed [BW-1:0] bv;
    for (int t = 0; t < hist_len; t++) begin
      if (t - j >= 0 && t - i >= 0) begin
        av = wh[t-j][i*BW +: BW];
        bv = nh[t-i][j*BW +: BW];
        s += (longint'(av) * longint'(bv)) >>> 8;
      end
    end
    return s;
  endfunction

  task automatic run_tile(input int klen, output int accepted, output int ready_cycles,
                          output int bubbles, output int t_last, output int t_done);
    int t = 0;
    int beat = 0;
    int pi = 0;
    bit v;
    bit rdy;
    accepted = 0; ready_cycles = 0; bubbles = 0; t_last = -1; t_done = -1;
    lane0_leak = 0;
    bus.start = 1'b1;
    bus.k_len = KW'(klen);
    tick();
    bus.start = 1'b0;
    while (t < HMAX - 1 && t_done < 0) begin
      wh[t] = bus.west_data;
      nh[t] = bus.north_data;
      if (bus.done) begin
        t_done = t;
      end else begin
        rdy = bus.in_ready;
        v = (beat < klen) ? ((pi < vpat.size()) ? vpat[pi] : 1'b1) : 1'b1;
        if (rdy) begin
          ready_cycles++;
          pi++;
          if (!v) bubbles++;
        end
        bus.in_valid = v;
        if (v && beat < klen) set_beat(beat);
        else begin
          bus.a_vec = {NN{16'hDEAD}};
          bus.b_vec = {NN{16'hBEEF}};
        end
        tick();
        if (v && rdy) begin
          beat++;
          accepted++;
          t_last = t;
        end else if (rdy && (bus.west_data[BW-1:0] != '0 || bus.north_data[BW-1:0] != '0)) begin
          lane0_leak++;
        end
        t++;
      end
    end
    bus.in_valid = 1'b0;
    hist_len = t + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rdyc, bub, tl, td, leaks;

    tbl[0] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0005, 1'b1, 1'b0};
    tbl[1] = '{64'h0000_0000_0002_0000, 64'h0000_0000_0006_0000, 1'b1, 1'b0};
    tbl[2] = '{64'h0000_0003_0000_0000, 64'h0000_0007_0000_0000, 1'b1, 1'b0};
    tbl[3] = '{64'h0004_0000_0000_0000, 64'h0008_0000_0000_0000, 1'b1, 1'b0};
    tbl[4] = '{64'h0, 64'h0, 1'b1, 1'b0};
    tbl[5] = '{64'h0, 64'h0, 1'b1, 1'b0};
    tbl[6] = '{64'h0, 64'h0, 1'b1, 1'b0};
    tbl[7] = '{64'h0, 64'h0, 1'b0, 1'b1};

    for (int i = 0; i < NN; i++) begin
      for (int j = 0; j < NN; j++) begin
        a_m[i][j] = (i == j) ? 256 : 0;
        b_m[i][j] = (i * NN + j + 1) * 256;
      end
    end

    bus.start = 1'b0; bus.k_len = '0; bus.in_valid = 1'b0;
    bus.a_vec = '0; bus.b_vec = '0;

    // Reset state
    #1;
    check("rst_west", bus.west_data, 64'h0);
    check("rst_north", bus.north_data, 64'h0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single beat, table-driven
    bus.start = 1'b1; bus.k_len = 8'd1;
    tick();
    bus.start = 1'b0;
    check("single_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.a_vec = {16'd4, 16'd3, 16'd2, 16'd1};
    bus.b_vec = {16'd8, 16'd7, 16'd6, 16'd5};
    tick();
    bus.in_valid = 1'b0;
    bus.a_vec = {NN{16'hDEAD}};
    bus.b_vec = {NN{16'hBEEF}};
    for (int d = 0; d < 8; d++) begin
      check($sformatf("single_west_c%0d", d + 1), bus.west_data, tbl[d].west);
      check($sformatf("single_north_c%0d", d + 1), bus.north_data, tbl[d].north);
      check($sformatf("single_busy_c%0d", d + 1), bus.busy, tbl[d].busy);
      check($sformatf("single_done_c%0d", d + 1), bus.done, tbl[d].done);
      check($sformatf("single_ready_c%0d", d + 1), bus.in_ready, 0);
      tick();
    end
    check("single_done_drop", bus.done, 0);

    // k_len = 0
    bus.start = 1'b1; bus.k_len = 8'd0;
    tick();
    bus.start = 1'b0;
    check("k0_done", bus.done, 1);
    check("k0_busy", bus.busy, 0);
    check("k0_ready", bus.in_ready, 0);
    check("k0_west", bus.west_data, 64'h0);
    tick();
    check("k0_done_drop", bus.done, 0);
    check("k0_ready_after", bus.in_ready, 0);

    // Reset mid-STREAM after two beats
    bus.start = 1'b1; bus.k_len = 8'd5;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; set_beat(0);
    tick();
    set_beat(1);
    tick();
    bus.in_valid = 1'b0;
    check("mid_north_pre", bus.north_data[BW-1:0], 16'h0500);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_west", bus.west_data, 64'h0);
    check("mid_rst_north", bus.north_data, 64'h0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_ready", bus.in_ready, 0);
    tick();
    rst = 1'b0;
    leaks = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done || bus.busy) leaks++;
      tick();
    end
    check("mid_no_done", leaks, 0);

    // Full identity x B tile
    vpat.delete();
    run_tile(4, acc, rdyc, bub, tl, td);
    check("full_accepted", acc, 4);
    check("full_ready_cycles", rdyc, 4);
    check("full_last_beat", tl, 3);
    check("full_done_time", td, 3 + 2 * NN);
    for (int i = 0; i < NN; i++) begin
      for (int j = 0; j < NN; j++) begin
        check($sformatf("full_pe_%0d_%0d", i, j), pe_acc(i, j), (i * NN + j + 1) * 256);
      end
    end
`ifdef FEEDER_BUBBLE_CNT_EN
    check("full_bubble_cnt", bus.bubble_cnt, 0);
`endif
    tick();

    // Bubbles 1,0,0,1,0,1 with k_len = 3
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_tile(3, acc, rdyc, bub, tl, td);
    check("bub_accepted", acc, 3);
    check("bub_ready_cycles", rdyc, 6);
    check("bub_driven", bub, 3);
    check("bub_lane0_zero", lane0_leak, 0);
    check("bub_done_time", td, 5 + 2 * NN);
    for (int i = 0; i < NN; i++) begin
      for (int j = 0; j < NN; j++) begin
        check($sformatf("bub_pe_%0d_%0d", i, j), pe_acc(i, j),
              (i < 3) ? (i * NN + j + 1) * 256 : 0);
      end
    end
`ifdef FEEDER_BUBBLE_CNT_EN
    check("bub_cnt", bus.bubble_cnt, 3);
    tick();
    check("bub_cnt_hold", bus.bubble_cnt, 3);
`else
    tick();
`endif
    vpat.delete();

    // start during FLUSH and on the DONE cycle is ignored
    bus.start = 1'b1; bus.k_len = 8'd1;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; set_beat(0);
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    bus.start = 1'b1; bus.k_len = 8'd5;
    tick();
    bus.start = 1'b0;
    check("flush_start_ready", bus.in_ready, 0);
    check("flush_start_busy", bus.busy, 1);
    tick(); tick(); tick(); tick();
    check("ign_done_cycle", bus.done, 1);
    bus.start = 1'b1; bus.k_len = 8'd5;
    tick();
    bus.start = 1'b0;
    check("ign_idle_ready", bus.in_ready, 0);
    check("ign_idle_busy", bus.busy, 0);
    check("ign_idle_done", bus.done, 0);
    run_tile(2, acc, rdyc, bub, tl, td);
    check("second_accepted", acc, 2);
    check("second_done_time", td, tl + 2 * NN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Source end of the systolic MAC array: drives the west edge (A operand) and north edge (B operand) of an N x N PE grid.
- Accepts one K-step beat per handshake: column k of the A tile and row k of the B tile. Applies the diagonal skew so lane i arrives i cycles later than lane 0.
- Flushes zeros after the last beat and pulses done once PE(N-1,N-1) has registered its final accumulation.

Parameters:
- BIT_WIDTH, 16, element width (Q-format, same as PE).
- N, 4, array dimension; number of west lanes and north lanes.
- K_W, 8, width of k_len; max tile depth 2^K_W-1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request to begin a tile; sampled only in IDLE.
- k_len  in  K_W  number of beats in the tile; sampled with start.
- in_valid  in  1  beat available.
- in_ready  out  1  feeder accepts a beat this cycle.
- a_vec  in  N*BIT_WIDTH  A column k; lane i = bits [i*BIT_WIDTH +: BIT_WIDTH] = A[i][k].
- b_vec  in  N*BIT_WIDTH  B row k; lane j = B[k][j].
- west_data  out  N*BIT_WIDTH  to data_west of PE row i (lane i).
- north_data  out  N*BIT_WIDTH  to data_north of PE column j (lane j).
- busy  out  1  high in STREAM and FLUSH.
- done  out  1  one-cycle pulse at tile completion.

Behaviour:
- Reset (async, rst=1): all skew registers 0, west_data=north_data=0, in_ready=0, busy=0, done=0, beat counter 0, flush counter 0, state IDLE. Reset mid-tile abandons the tile; no done is issued.
- States: IDLE, STREAM, FLUSH, DONE.
- IDLE:
  - start=1 with k_len>0 latches k_len and goes to STREAM.
  - start=1 with k_len=0 goes directly to DONE.
- STREAM:
  - in_ready=1.
  - Beat accepted on a clock edge where in_valid && in_ready. The accepted lanes enter the skew lines and the beat counter increments.
  - in_valid=0 injects a bubble: zeros on all lanes of both operands in the same cycle. Bubbles pair zero with zero in every PE, so accumulations are unaffected.
  - The edge accepting beat k_len moves to FLUSH; in_ready drops the following cycle.
- FLUSH:
  - in_ready=0; zeros are injected on all lanes.
  - Lasts exactly 2N-1 cycles, counted from the cycle after the last accepting edge. Go to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- start outside IDLE is ignored. start and the first beat cannot coincide: in_ready is 0 in IDLE.
- Skew: lane i of each operand passes through 1+i register stages.
  - A beat accepted at edge c appears on lane 0 in cycle c+1 and on lane i in cycle c+1+i.
  - PE(i,j) multiplies matching A[i][k] and B[k][j] in cycle c+1+i+j.
  - The last product (PE(N-1,N-1)) is used in cycle c+2N-1 and registered at its end. done is high in cycle c+2N.
- Data is passed through unmodified; no arithmetic or saturation in this block.
- Tiles are back-to-back capable: start may be asserted in the IDLE cycle immediately after DONE.
- PE accumulators are not cleared by this block; clearing between tiles is the array's responsibility (reset).

Optional Feature:
- Macro FEEDER_BUBBLE_CNT_EN.
- Defined: adds output port bubble_cnt (16 bits), counting STREAM cycles with in_valid=0. It saturates at 0xFFFF, clears on rst and on each accepted start, and holds its value after done.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package sa_pkg: BIT_WIDTH/N defaults, the feeder state encoding (IDLE, STREAM, FLUSH, DONE), and the FLUSH_LEN = 2N-1 constant function.
- One sub-module, skew_line: parameterised DEPTH x BIT_WIDTH shift register with async reset to 0.
  - Instantiated 2N times via generate, with DEPTH = 1+i.

Test Plan:
- Reset mid-STREAM (N=4, k_len=5, after 2 beats, assert rst) -> west_data=north_data=0 and busy=0 immediately (asynchronously); no done; next start runs a clean tile.
- Single beat (N=4, k_len=1, a_vec lanes 1,2,3,4, b_vec lanes 5,6,7,8; beat accepted at edge c) -> lane i of west_data holds i+1 only in cycle c+1+i; done high exactly in cycle c+8.
- Full 4x4 tile with 4x4 array (k_len=4, A=identity, B=[1..16] in Q8.8, in_valid always 1) -> in_ready high for 4 cycles; PE results equal B after done; done 8 cycles after the 4th beat.
- Bubbles (k_len=3, in_valid pattern 1,0,0,1,0,1) -> 3 beats accepted; zero lanes injected in gap cycles; final PE results identical to the no-bubble run; with FEEDER_BUBBLE_CNT_EN, bubble_cnt=3.
- k_len=0 start -> done pulses the next cycle; in_ready never high; outputs stay 0.
- start asserted during FLUSH and on the DONE cycle -> ignored; start in the following IDLE cycle is accepted and a second tile completes.
